// File: rtl/fxp_pkg.sv
// Shared fixed-point format constants and the exact narrow-to-wide conversion
// used by the psum unpack path and the rounding stage's reference model.
package fxp_pkg;

   localparam int IN_WIDTH_DEF  = 16;
   localparam int IN_FRAC_DEF   = 13;
   localparam int OUT_WIDTH_DEF = 33;
   localparam int OUT_FRAC_DEF  = 26;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic {
      LANE0 = 1'b0,
      LANE1 = 1'b1
   } lane_sel_t;

   // Sign-extend a Q2.13 lane to 33 bits, then align the binary point to Q6.26.
   function automatic logic [OUT_WIDTH_DEF-1:0] widen(input logic [IN_WIDTH_DEF-1:0] lane);
      logic signed [OUT_WIDTH_DEF-1:0] ext;
      ext = OUT_WIDTH_DEF'($signed(lane));
      return ext << (OUT_FRAC_DEF - IN_FRAC_DEF);
   endfunction

endpackage

// File: rtl/fxp_widen_lane.sv
// Combinational exact widening of one narrow fixed-point lane: sign-extend to
// the wide width, then shift left so both formats share the binary point.
module fxp_widen_lane #(
   parameter int IN_WIDTH  = 16,
   parameter int IN_FRAC   = 13,
   parameter int OUT_WIDTH = 33,
   parameter int OUT_FRAC  = 26
) (
   input  logic [IN_WIDTH-1:0]  lane,
   output logic [OUT_WIDTH-1:0] wide
);

   localparam int SHIFT = OUT_FRAC - IN_FRAC;

   logic signed [OUT_WIDTH-1:0] ext;

   assign ext  = OUT_WIDTH'($signed(lane));
   assign wide = ext << SHIFT;

endmodule

// File: rtl/fxp_widen_unpack.sv
// Unpacks two-lane narrow psum words from the global buffer and streams each
// lane, exactly widened, into the accumulate path one lane per cycle.
module fxp_widen_unpack
   import fxp_pkg::*;
#(
   parameter int IN_WIDTH  = IN_WIDTH_DEF,
   parameter int IN_FRAC   = IN_FRAC_DEF,
   parameter int OUT_WIDTH = OUT_WIDTH_DEF,
   parameter int OUT_FRAC  = OUT_FRAC_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  EN,
   input  logic                  S_VALID,
   output logic                  S_READY,
   input  logic [2*IN_WIDTH-1:0] S_DATA,
   input  logic                  S_HALF,
   input  logic                  S_LAST,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic [OUT_WIDTH-1:0]  M_DATA,
   output logic                  M_LAST,
   output logic [CNT_WIDTH-1:0]  M_CNT
);

   generate
      if (OUT_FRAC < IN_FRAC || (OUT_WIDTH - OUT_FRAC) < (IN_WIDTH - IN_FRAC)) begin : g_bad_format
         $error("fxp_widen_unpack: wide format cannot represent the narrow format exactly");
      end
   endgenerate

   logic                  buf_valid_reg;
   logic [2*IN_WIDTH-1:0] buf_data_reg;
   logic                  buf_half_reg;
   logic                  buf_last_reg;
   lane_sel_t             lane_reg, lane_next;
   logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
   logic                  m_valid_reg;
   logic [OUT_WIDTH-1:0]  m_data_reg;
   logic                  m_last_reg;
   logic [CNT_WIDTH-1:0]  m_cnt_reg;

   logic [IN_WIDTH-1:0]   lanes [2];
   logic [IN_WIDTH-1:0]   lane_data;
   logic [OUT_WIDTH-1:0]  lane_wide;
   logic                  final_lane;
   logic                  load;
   logic                  s_ready;
   logic                  accept;

   for (genvar gi = 0; gi < 2; gi++) begin : g_lanes
      assign lanes[gi] = buf_data_reg[gi*IN_WIDTH +: IN_WIDTH];
   end

   assign lane_data  = (lane_reg == LANE1) ? lanes[1] : lanes[0];
   assign final_lane = buf_half_reg | (lane_reg == LANE1);
   assign load       = EN & buf_valid_reg & (~m_valid_reg | M_READY);
   // Freeing the buffer on the final-lane load lets the next word in on the same edge.
   assign s_ready    = EN & ~RESET & (~buf_valid_reg | (load & final_lane));
   assign accept     = S_VALID & s_ready;

   fxp_widen_lane #(
      .IN_WIDTH  (IN_WIDTH),
      .IN_FRAC   (IN_FRAC),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_FRAC  (OUT_FRAC)
   ) u_widen_lane (
      .lane (lane_data),
      .wide (lane_wide)
   );

   always_comb begin
      lane_next = lane_reg;
      cnt_next  = cnt_reg;
      if (load) begin
         lane_next = final_lane ? LANE0 : LANE1;
         cnt_next  = (buf_last_reg & final_lane) ? '0 : cnt_reg + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         buf_valid_reg <= 1'b0;
         buf_data_reg  <= '0;
         buf_half_reg  <= 1'b0;
         buf_last_reg  <= 1'b0;
         lane_reg      <= LANE0;
         cnt_reg       <= '0;
         m_valid_reg   <= 1'b0;
         m_data_reg    <= '0;
         m_last_reg    <= 1'b0;
         m_cnt_reg     <= '0;
      end else if (EN) begin
         lane_reg <= lane_next;
         cnt_reg  <= cnt_next;
         if (load) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= lane_wide;
            m_last_reg  <= buf_last_reg & final_lane;
            m_cnt_reg   <= cnt_reg;
         end else if (M_READY) begin
            m_valid_reg <= 1'b0;
         end
         if (accept) begin
            buf_valid_reg <= 1'b1;
            buf_data_reg  <= S_DATA;
            buf_half_reg  <= S_HALF;
            buf_last_reg  <= S_LAST;
         end else if (load && final_lane) begin
            buf_valid_reg <= 1'b0;
         end
      end
   end

   assign S_READY = s_ready;
   assign M_VALID = m_valid_reg;
   assign M_DATA  = m_data_reg;
   assign M_LAST  = m_last_reg;
   assign M_CNT   = m_cnt_reg;

endmodule

// File: tb/tb_fxp_widen_unpack.sv
// Self-checking bench for fxp_widen_unpack: directed scenarios plus a random
// packed stream compared against an arithmetic queue model.
module tb_fxp_widen_unpack;

   logic        CLK = 1'b0;
   logic        RESET, EN, S_VALID, S_READY, S_HALF, S_LAST;
   logic        M_VALID, M_READY, M_LAST;
   logic [31:0] S_DATA;
   logic [32:0] M_DATA;
   logic [15:0] M_CNT;

   always #5 CLK = ~CLK;

   fxp_widen_unpack dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .EN      (EN),
      .S_VALID (S_VALID),
      .S_READY (S_READY),
      .S_DATA  (S_DATA),
      .S_HALF  (S_HALF),
      .S_LAST  (S_LAST),
      .M_VALID (M_VALID),
      .M_READY (M_READY),
      .M_DATA  (M_DATA),
      .M_LAST  (M_LAST),
      .M_CNT   (M_CNT)
   );

   typedef struct {
      logic [31:0] data;
      logic        half;
      logic        last;
   } word_t;

   typedef struct {
      logic [32:0] data;
      logic        last;
      logic [15:0] cnt;
   } out_t;

   word_t       stim_q[$];
   out_t        exp_q[$];
   out_t        obs_q[$];
   logic        sready_log[$];
   logic [15:0] model_cnt;
   int          en_pct, rdy_pct, val_pct;
   int          checks = 0;
   int          passes = 0;

   // Q2.13 value times 2^13 is the same real number in Q6.26, kept modulo 2^33.
   function automatic logic [32:0] ref_widen(input logic [15:0] lane);
      longint v;
      v = longint'($signed(lane)) * 64'sd8192;
      return v[32:0];
   endfunction

   function automatic void model_push(input logic [15:0] lane, input logic is_last);
      out_t o;
      o.data = ref_widen(lane);
      o.last = is_last;
      o.cnt  = model_cnt;
      exp_q.push_back(o);
      model_cnt = is_last ? 16'd0 : model_cnt + 16'd1;
   endfunction

   task automatic run_stream(input int max_cycles);
      int    cyc;
      word_t w;
      out_t  e, o;
      cyc = 0;
      model_cnt = 16'd0;
      obs_q.delete();
      sready_log.delete();
      while ((stim_q.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
         @(negedge CLK);
         cyc++;
         EN      = ($urandom_range(99) < en_pct);
         M_READY = ($urandom_range(99) < rdy_pct);
         S_VALID = (stim_q.size() != 0) && ($urandom_range(99) < val_pct);
         if (S_VALID) begin
            S_DATA = stim_q[0].data;
            S_HALF = stim_q[0].half;
            S_LAST = stim_q[0].last;
         end else begin
            S_DATA = $urandom;
            S_HALF = $urandom_range(1);
            S_LAST = $urandom_range(1);
         end
         #1;
         sready_log.push_back(S_READY);
         if (EN && M_VALID && M_READY) begin
            o.data = M_DATA;
            o.last = M_LAST;
            o.cnt  = M_CNT;
            obs_q.push_back(o);
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL stream_extra: got data=%h last=%b cnt=%0d, expected no output", o.data, o.last, o.cnt);
            end else begin
               e = exp_q.pop_front();
               if ({o.data, o.last, o.cnt} !== {e.data, e.last, e.cnt})
                  $display("FAIL stream_out: got data=%h last=%b cnt=%0d, expected data=%h last=%b cnt=%0d",
                           o.data, o.last, o.cnt, e.data, e.last, e.cnt);
               else
                  passes++;
            end
         end
         if (S_VALID && S_READY) begin
            w = stim_q.pop_front();
            model_push(w.data[15:0], w.last & w.half);
            if (!w.half) model_push(w.data[31:16], w.last);
         end
      end
      @(negedge CLK);
      S_VALID = 1'b0;
      EN      = 1'b1;
      M_READY = 1'b1;
      #1;
      checks++;
      if (stim_q.size() != 0 || exp_q.size() != 0 || M_VALID !== 1'b0)
         $display("FAIL stream_done: got words_left=%0d outputs_left=%0d m_valid=%b, expected 0 0 0",
                  stim_q.size(), exp_q.size(), M_VALID);
      else
         passes++;
      stim_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      RESET = 1'b1; EN = 1'b1; S_VALID = 1'b1; S_DATA = 32'h1234_5678; M_READY = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      checks++; if (M_VALID !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", M_VALID); else passes++;
      checks++; if (M_DATA !== 33'd0) $display("FAIL reset_m_data: got %h expected 0", M_DATA); else passes++;
      checks++; if (M_LAST !== 1'b0) $display("FAIL reset_m_last: got %b expected 0", M_LAST); else passes++;
      checks++; if (M_CNT !== 16'd0) $display("FAIL reset_m_cnt: got %0d expected 0", M_CNT); else passes++;
      checks++; if (S_READY !== 1'b0) $display("FAIL reset_s_ready: got %b expected 0", S_READY); else passes++;
      @(negedge CLK);
      RESET = 1'b0; S_VALID = 1'b0;
   endtask

   task automatic test_basic();
      en_pct = 100; rdy_pct = 100; val_pct = 100;
      stim_q.push_back('{data: 32'hE000_2000, half: 1'b0, last: 1'b1});
      run_stream(50);
      checks++;
      if (obs_q.size() != 2) $display("FAIL basic_count: got %0d expected 2", obs_q.size()); else passes++;
      if (obs_q.size() >= 2) begin
         checks++;
         if ({obs_q[0].data, obs_q[0].last, obs_q[0].cnt} !== {33'h004000000, 1'b0, 16'd0})
            $display("FAIL basic_lane0: got %h/%b/%0d expected 004000000/0/0", obs_q[0].data, obs_q[0].last, obs_q[0].cnt);
         else passes++;
         checks++;
         if ({obs_q[1].data, obs_q[1].last, obs_q[1].cnt} !== {33'h1FC000000, 1'b1, 16'd1})
            $display("FAIL basic_lane1: got %h/%b/%0d expected 1fc000000/1/1", obs_q[1].data, obs_q[1].last, obs_q[1].cnt);
         else passes++;
      end
   endtask

   task automatic test_extremes();
      logic [32:0] req [3];
      req[0] = 33'h00FFFE000; req[1] = 33'h1F0000000; req[2] = 33'h000002000;
      en_pct = 100; rdy_pct = 100; val_pct = 100;
      stim_q.push_back('{data: 32'h8000_7FFF, half: 1'b0, last: 1'b0});
      stim_q.push_back('{data: 32'h0000_0001, half: 1'b1, last: 1'b1});
      run_stream(50);
      checks++;
      if (obs_q.size() != 3) $display("FAIL extremes_count: got %0d expected 3", obs_q.size()); else passes++;
      for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
         checks++;
         if ({obs_q[i].data, obs_q[i].last, obs_q[i].cnt} !== {req[i], 1'(i == 2), 16'(i)})
            $display("FAIL extremes_%0d: got %h/%b/%0d expected %h/%b/%0d",
                     i, obs_q[i].data, obs_q[i].last, obs_q[i].cnt, req[i], i == 2, i);
         else passes++;
      end
   endtask

   task automatic test_stream_half();
      en_pct = 100; rdy_pct = 100; val_pct = 100;
      stim_q.push_back('{data: $urandom, half: 1'b0, last: 1'b0});
      stim_q.push_back('{data: $urandom, half: 1'b0, last: 1'b0});
      stim_q.push_back('{data: $urandom, half: 1'b1, last: 1'b1});
      run_stream(50);
      checks++;
      if (obs_q.size() != 5) $display("FAIL half_count: got %0d expected 5", obs_q.size()); else passes++;
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         checks++;
         if ({obs_q[i].last, obs_q[i].cnt} !== {1'(i == 4), 16'(i)})
            $display("FAIL half_seq_%0d: got last=%b cnt=%0d expected last=%b cnt=%0d", i, obs_q[i].last, obs_q[i].cnt, i == 4, i);
         else passes++;
      end
      for (int i = 0; i < 5 && i < sready_log.size(); i++) begin
         checks++;
         if (sready_log[i] !== 1'((i % 2) == 0))
            $display("FAIL half_sready_%0d: got %b expected %b", i, sready_log[i], (i % 2) == 0);
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] a0, a1, b0, b1;
      a0 = ref_widen(16'h0F0F); a1 = ref_widen(16'h1234);
      b0 = ref_widen(16'h5555); b1 = ref_widen(16'hABCD);
      @(negedge CLK);
      EN = 1'b1; M_READY = 1'b1; S_VALID = 1'b1; S_DATA = 32'h1234_0F0F; S_HALF = 1'b0; S_LAST = 1'b1;
      #1;
      checks++; if (S_READY !== 1'b1) $display("FAIL bp_accept: got %b expected 1", S_READY); else passes++;
      @(negedge CLK);
      S_DATA = 32'hABCD_5555;
      #1;
      checks++; if (S_READY !== 1'b0) $display("FAIL bp_busy: got %b expected 0", S_READY); else passes++;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         M_READY = 1'b0;
         #1;
         checks++;
         if ({M_VALID, M_DATA, M_CNT, S_READY} !== {1'b1, a0, 16'd0, 1'b0})
            $display("FAIL bp_hold_%0d: got v=%b d=%h c=%0d r=%b expected v=1 d=%h c=0 r=0", i, M_VALID, M_DATA, M_CNT, S_READY, a0);
         else passes++;
      end
      @(negedge CLK);
      M_READY = 1'b1;
      #1;
      checks++;
      if ({M_VALID, M_DATA, S_READY} !== {1'b1, a0, 1'b1})
         $display("FAIL bp_release: got v=%b d=%h r=%b expected v=1 d=%h r=1", M_VALID, M_DATA, S_READY, a0);
      else passes++;
      @(negedge CLK);
      S_VALID = 1'b0;
      #1;
      checks++;
      if ({M_VALID, M_DATA, M_LAST, M_CNT} !== {1'b1, a1, 1'b1, 16'd1})
         $display("FAIL bp_a1: got v=%b d=%h l=%b c=%0d expected v=1 d=%h l=1 c=1", M_VALID, M_DATA, M_LAST, M_CNT, a1);
      else passes++;
      @(negedge CLK); #1;
      checks++;
      if ({M_VALID, M_DATA, M_LAST, M_CNT} !== {1'b1, b0, 1'b0, 16'd0})
         $display("FAIL bp_b0: got v=%b d=%h l=%b c=%0d expected v=1 d=%h l=0 c=0", M_VALID, M_DATA, M_LAST, M_CNT, b0);
      else passes++;
      @(negedge CLK); #1;
      checks++;
      if ({M_VALID, M_DATA, M_LAST, M_CNT} !== {1'b1, b1, 1'b1, 16'd1})
         $display("FAIL bp_b1: got v=%b d=%h l=%b c=%0d expected v=1 d=%h l=1 c=1", M_VALID, M_DATA, M_LAST, M_CNT, b1);
      else passes++;
      @(negedge CLK); #1;
      checks++; if (M_VALID !== 1'b0) $display("FAIL bp_drained: got %b expected 0", M_VALID); else passes++;
   endtask

   task automatic test_en_freeze_reset();
      logic [32:0] c0, c1, d0, e0, e1;
      c0 = ref_widen(16'hC000); c1 = ref_widen(16'h4000);
      d0 = ref_widen(16'h0007);
      e0 = ref_widen(16'h0002); e1 = ref_widen(16'h0003);
      @(negedge CLK);
      EN = 1'b1; M_READY = 1'b1; S_VALID = 1'b1; S_DATA = 32'h4000_C000; S_HALF = 1'b0; S_LAST = 1'b0;
      @(negedge CLK);
      S_VALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         EN = 1'b0;
         #1;
         checks++;
         if ({M_VALID, M_DATA, M_CNT, S_READY} !== {1'b1, c0, 16'd0, 1'b0})
            $display("FAIL en_freeze_%0d: got v=%b d=%h c=%0d r=%b expected v=1 d=%h c=0 r=0", i, M_VALID, M_DATA, M_CNT, S_READY, c0);
         else passes++;
      end
      @(negedge CLK);
      EN = 1'b1;
      @(negedge CLK);
      S_VALID = 1'b1; S_DATA = 32'h0005_0007; S_LAST = 1'b1;
      #1;
      checks++;
      if ({M_VALID, M_DATA, M_LAST, M_CNT} !== {1'b1, c1, 1'b0, 16'd1})
         $display("FAIL en_resume: got v=%b d=%h l=%b c=%0d expected v=1 d=%h l=0 c=1", M_VALID, M_DATA, M_LAST, M_CNT, c1);
      else passes++;
      @(negedge CLK);
      S_VALID = 1'b0;
      @(negedge CLK); #1;
      checks++;
      if ({M_VALID, M_DATA, M_CNT} !== {1'b1, d0, 16'd2})
         $display("FAIL rst_pre: got v=%b d=%h c=%0d expected v=1 d=%h c=2", M_VALID, M_DATA, M_CNT, d0);
      else passes++;
      RESET = 1'b1;
      #1;
      checks++; if (S_READY !== 1'b0) $display("FAIL rst_sready: got %b expected 0", S_READY); else passes++;
      @(negedge CLK);
      RESET = 1'b0; S_VALID = 1'b1; S_DATA = 32'h0003_0002; S_HALF = 1'b0; S_LAST = 1'b1;
      #1;
      checks++;
      if ({M_VALID, M_DATA, M_CNT} !== {1'b0, 33'd0, 16'd0})
         $display("FAIL rst_cleared: got v=%b d=%h c=%0d expected v=0 d=0 c=0", M_VALID, M_DATA, M_CNT);
      else passes++;
      @(negedge CLK);
      S_VALID = 1'b0;
      @(negedge CLK); #1;
      checks++;
      if ({M_VALID, M_DATA, M_LAST, M_CNT} !== {1'b1, e0, 1'b0, 16'd0})
         $display("FAIL rst_new_e0: got v=%b d=%h l=%b c=%0d expected v=1 d=%h l=0 c=0", M_VALID, M_DATA, M_LAST, M_CNT, e0);
      else passes++;
      @(negedge CLK); #1;
      checks++;
      if ({M_VALID, M_DATA, M_LAST, M_CNT} !== {1'b1, e1, 1'b1, 16'd1})
         $display("FAIL rst_new_e1: got v=%b d=%h l=%b c=%0d expected v=1 d=%h l=1 c=1", M_VALID, M_DATA, M_LAST, M_CNT, e1);
      else passes++;
      @(negedge CLK); #1;
      checks++; if (M_VALID !== 1'b0) $display("FAIL rst_drained: got %b expected 0", M_VALID); else passes++;
   endtask

   task automatic test_random();
      word_t w;
      en_pct = 85; rdy_pct = 70; val_pct = 80;
      for (int i = 0; i < 200; i++) begin
         w.data = $urandom;
         if ($urandom_range(9) == 0) w.data[15:0] = 16'h8000;
         if ($urandom_range(9) == 0) w.data[31:16] = 16'h7FFF;
         w.half = ($urandom_range(3) == 0);
         w.last = ($urandom_range(3) == 0) || (i == 199);
         stim_q.push_back(w);
      end
      run_stream(5000);
   endtask

   initial begin
      RESET = 1'b1; EN = 1'b0; S_VALID = 1'b0; S_DATA = '0; S_HALF = 1'b0; S_LAST = 1'b0; M_READY = 1'b0;
      test_reset();
      test_basic();
      test_extremes();
      test_stream_half();
      test_backpressure();
      test_en_freeze_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fxp_widen_unpack.md
Name: fxp_widen_unpack

Overview:
- Inverse companion to the PE output rounding/saturation stage.
- Takes packed narrow fixed-point psums (two Q2.13 lanes per word) from the global buffer read path.
- Unpacks each word and sign-extends/aligns every lane exactly into the wide accumulator format (Q6.26, 33 bit).
- Feeds the psum accumulate path with valid/ready flow control, one lane per cycle.

Parameters:
- IN_WIDTH, 16, width of one narrow lane.
- IN_FRAC, 13, fractional bits of the narrow lane.
- OUT_WIDTH, 33, width of the wide output.
- OUT_FRAC, 26, fractional bits of the wide output.
- CNT_WIDTH, 16, width of the per-packet output beat counter.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  clock enable; when low, all state holds and S_READY=0.
- S_VALID  in  1  input word valid.
- S_READY  out  1  input word accepted when S_VALID&S_READY&EN.
- S_DATA  in  2*IN_WIDTH  packed lanes; lane0=[IN_WIDTH-1:0], lane1=upper.
- S_HALF  in  1  only lane0 meaningful (odd-length tail).
- S_LAST  in  1  word is the last of the packet.
- M_VALID  out  1  output valid.
- M_READY  in  1  downstream ready.
- M_DATA  out  OUT_WIDTH  widened signed value.
- M_LAST  out  1  final lane of the packet.
- M_CNT  out  CNT_WIDTH  index of the current output within the packet (0-based).

Behaviour:
- Elaboration check: fail if OUT_FRAC<IN_FRAC or (OUT_WIDTH-OUT_FRAC)<(IN_WIDTH-IN_FRAC).
- Conversion is exact: sign-extend the lane to OUT_WIDTH, then shift left by OUT_FRAC-IN_FRAC and zero-fill.
  - No rounding, no saturation, no flags.
- Reset values: M_VALID=0, M_DATA=0, M_LAST=0, M_CNT=0, S_READY=0 during reset. Internal buffer empty, lane select=0.
- Storage:
  - One input word buffer (buf_valid, data, half, last) plus a lane-select bit.
  - One output register (M_VALID, M_DATA, M_LAST, M_CNT).
- Output load condition: load = EN & buf_valid & (!M_VALID | M_READY).
  - The load writes the selected lane. M_LAST = buf_last & (lane is the final lane).
  - Final lane is lane0 if half, else lane1.
- Lane select FSM:
  - LANE0 -> LANE1 on load when !half.
  - LANE0 or LANE1 -> buffer freed on load of the final lane; lane select returns to LANE0.
- S_READY = EN & !RESET & (!buf_valid | (load & final lane)).
  - Combinational, so a new word loads into the buffer the same cycle the last lane moves out.
- M_VALID clears when M_READY & !load; it holds under backpressure with data, last and count stable.
- Throughput: one output per cycle. Full words are accepted every 2 cycles; half words every cycle.
- Latency: a word accepted in cycle t gives its lane0 at M_* in cycle t+1.
- M_CNT:
  - Value of a per-packet counter captured at load time; the counter increments per load.
  - It clears to 0 after the load carrying M_LAST.
  - Wraps modulo 2^CNT_WIDTH with no flag.
- EN=0: nothing accepted or emitted; M_VALID/M_DATA hold; M_READY is ignored.
- RESET mid-packet: buffer and output discarded, counter cleared. The next word starts a new packet.
- S_HALF on a non-last word is legal: it emits a single lane, and the packet continues.

Decomposition:
- Shared package fxp_pkg holds the format constants IN_WIDTH/IN_FRAC/OUT_WIDTH/OUT_FRAC defaults and a widen function.
  - The widen function is shared with the rounding stage's verification model.
- One natural sub-module: fxp_widen_lane, a pure combinational sign-extend-and-align of one lane, instantiated once after the lane mux.

Test Plan:
- Word {lane1=0xE000, lane0=0x2000}, S_LAST=1, M_READY=1 -> 0x004000000 (CNT0, LAST0), then 0x1FC000000 (CNT1, LAST1).
- Extremes 0x7FFF and 0x8000 -> 0x00FFFE000 and 0x1F0000000; 0x0001 -> 0x000002000.
- Stream of 3 words, last one S_HALF=1 -> 5 outputs, CNT 0..4, LAST only on the 5th; S_READY high every other cycle.
- Hold M_READY=0 for 4 cycles mid-word -> M_DATA/M_CNT stable, S_READY=0, no lane lost or duplicated after release.
- EN low 3 cycles during a packet -> state frozen; RESET asserted after lane0 of a word -> M_VALID=0 next cycle, next packet restarts at CNT 0.
- Random packed stream with random backpressure vs fxp_pkg widen model -> bit-exact, ordered outputs.
